// File: rtl/rv32_id_ex_stage_if.sv
// Bundle of ID-side request, forwarding sources and EX-side results around the ID/EX register.
// The master view is the surrounding pipeline (ID, MEM/WB forwarding, EX consumer); the slave view is the stage.
interface rv32_id_ex_stage_if #(
    parameter int XLEN        = 32,
    parameter int OPSEL_W     = 4,
    parameter int STALL_CNT_W = 16
);
    logic                   flush;
    logic                   id_valid;
    logic                   id_ready;
    logic [XLEN-1:0]        id_pc;
    logic [XLEN-1:0]        id_rs1_data;
    logic [XLEN-1:0]        id_rs2_data;
    logic [XLEN-1:0]        id_imm;
    logic [4:0]             id_rs1_addr;
    logic [4:0]             id_rs2_addr;
    logic [4:0]             id_rd_addr;
    logic [OPSEL_W-1:0]     id_alu_opsel;
    logic                   id_use_imm;
    logic                   id_reg_write;
    logic                   mem_fwd_en;
    logic [4:0]             mem_fwd_rd;
    logic [XLEN-1:0]        mem_fwd_data;
    logic                   wb_fwd_en;
    logic [4:0]             wb_fwd_rd;
    logic [XLEN-1:0]        wb_fwd_data;
    logic                   ex_valid;
    logic                   ex_ready;
    logic [XLEN-1:0]        ex_opA;
    logic [XLEN-1:0]        ex_opB;
    logic [XLEN-1:0]        ex_store_data;
    logic [OPSEL_W-1:0]     ex_alu_opsel;
    logic [4:0]             ex_rd_addr;
    logic                   ex_reg_write;
    logic [XLEN-1:0]        ex_pc;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_opsel, id_use_imm, id_reg_write,
               mem_fwd_en, mem_fwd_rd, mem_fwd_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data, ex_ready,
        input  id_ready, ex_valid, ex_opA, ex_opB, ex_store_data, ex_alu_opsel,
               ex_rd_addr, ex_reg_write, ex_pc, stall_cnt
    );

    modport slave (
        input  flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_opsel, id_use_imm, id_reg_write,
               mem_fwd_en, mem_fwd_rd, mem_fwd_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data, ex_ready,
        output id_ready, ex_valid, ex_opA, ex_opB, ex_store_data, ex_alu_opsel,
               ex_rd_addr, ex_reg_write, ex_pc, stall_cnt
    );
endinterface

// File: rtl/rv32_id_ex_stage.sv
// ID/EX pipeline register of the RV32I core: valid/ready handshake, RS1/RS2 forwarding
// from EX/MEM and MEM/WB, immediate-vs-RS2 operand select, and a saturating stall counter.
module rv32_id_ex_stage #(
    parameter int XLEN        = 32,
    parameter int OPSEL_W     = 4,
    parameter int STALL_CNT_W = 16
) (
    input logic               clk,
    input logic               rst_n,
    rv32_id_ex_stage_if.slave bus
);

    logic                   valid_q,    valid_d;
    logic [XLEN-1:0]        pc_q,       pc_d;
    logic [XLEN-1:0]        rs1_q,      rs1_d;
    logic [XLEN-1:0]        rs2_q,      rs2_d;
    logic [XLEN-1:0]        imm_q,      imm_d;
    logic [4:0]             rs1Addr_q,  rs1Addr_d;
    logic [4:0]             rs2Addr_q,  rs2Addr_d;
    logic [4:0]             rdAddr_q,   rdAddr_d;
    logic [OPSEL_W-1:0]     opsel_q,    opsel_d;
    logic                   useImm_q,   useImm_d;
    logic                   regWrite_q, regWrite_d;
    logic [STALL_CNT_W-1:0] stallCnt_q, stallCnt_d;

    logic idReady;
    logic capture;
    logic hold;

    // MEM/WB results take priority over the stored value; x0 is never forwarded.
    function automatic logic [XLEN-1:0] fwdSel(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] base,
        input logic            memEn,
        input logic [4:0]      memRd,
        input logic [XLEN-1:0] memData,
        input logic            wbEn,
        input logic [4:0]      wbRd,
        input logic [XLEN-1:0] wbData
    );
        if (memEn && (memRd == addr) && (addr != 5'd0)) begin
            return memData;
        end else if (wbEn && (wbRd == addr) && (addr != 5'd0)) begin
            return wbData;
        end
        return base;
    endfunction

    assign idReady = !valid_q || bus.ex_ready;
    assign capture = bus.id_valid && idReady && !bus.flush;
    assign hold    = valid_q && !bus.ex_ready && !bus.flush;

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        imm_d      = imm_q;
        rs1Addr_d  = rs1Addr_q;
        rs2Addr_d  = rs2Addr_q;
        rdAddr_d   = rdAddr_q;
        opsel_d    = opsel_q;
        useImm_d   = useImm_q;
        regWrite_d = regWrite_q;
        stallCnt_d = stallCnt_q;

        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (bus.id_valid && idReady) begin
            valid_d = 1'b1;
        end else if (bus.ex_ready) begin
            valid_d = 1'b0;
        end

        if (capture) begin
            pc_d       = bus.id_pc;
            imm_d      = bus.id_imm;
            rs1Addr_d  = bus.id_rs1_addr;
            rs2Addr_d  = bus.id_rs2_addr;
            rdAddr_d   = bus.id_rd_addr;
            opsel_d    = bus.id_alu_opsel;
            useImm_d   = bus.id_use_imm;
            regWrite_d = bus.id_reg_write;
            rs1_d = fwdSel(bus.id_rs1_addr, bus.id_rs1_data, bus.mem_fwd_en, bus.mem_fwd_rd,
                           bus.mem_fwd_data, bus.wb_fwd_en, bus.wb_fwd_rd, bus.wb_fwd_data);
            rs2_d = fwdSel(bus.id_rs2_addr, bus.id_rs2_data, bus.mem_fwd_en, bus.mem_fwd_rd,
                           bus.mem_fwd_data, bus.wb_fwd_en, bus.wb_fwd_rd, bus.wb_fwd_data);
        end else if (hold) begin
            // Keep snooping while stalled so a result retiring now is not lost to the stale copy.
            rs1_d = fwdSel(rs1Addr_q, rs1_q, bus.mem_fwd_en, bus.mem_fwd_rd,
                           bus.mem_fwd_data, bus.wb_fwd_en, bus.wb_fwd_rd, bus.wb_fwd_data);
            rs2_d = fwdSel(rs2Addr_q, rs2_q, bus.mem_fwd_en, bus.mem_fwd_rd,
                           bus.mem_fwd_data, bus.wb_fwd_en, bus.wb_fwd_rd, bus.wb_fwd_data);
        end

        if (valid_q && !bus.ex_ready && (stallCnt_q != {STALL_CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            rs1Addr_q  <= '0;
            rs2Addr_q  <= '0;
            rdAddr_q   <= '0;
            opsel_q    <= '0;
            useImm_q   <= 1'b0;
            regWrite_q <= 1'b0;
            stallCnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            imm_q      <= imm_d;
            rs1Addr_q  <= rs1Addr_d;
            rs2Addr_q  <= rs2Addr_d;
            rdAddr_q   <= rdAddr_d;
            opsel_q    <= opsel_d;
            useImm_q   <= useImm_d;
            regWrite_q <= regWrite_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign bus.id_ready      = idReady;
    assign bus.ex_valid      = valid_q;
    assign bus.ex_opA        = rs1_q;
    assign bus.ex_store_data = rs2_q;
    assign bus.ex_opB        = useImm_q ? imm_q : rs2_q;
    assign bus.ex_alu_opsel  = opsel_q;
    assign bus.ex_rd_addr    = rdAddr_q;
    assign bus.ex_reg_write  = regWrite_q && valid_q;
    assign bus.ex_pc         = pc_q;
    assign bus.stall_cnt     = stallCnt_q;

endmodule

// File: tb/tb_rv32_id_ex_stage.sv
// Directed bench for rv32_id_ex_stage: expected EX-side results are queued when an instruction
// is issued and compared when it appears on the EX side.
module tb_rv32_id_ex_stage;

    typedef struct {
        logic [31:0] opA;
        logic [31:0] opB;
        logic [31:0] store;
        logic [3:0]  opsel;
        logic [4:0]  rd;
        logic        regWrite;
        logic [31:0] pc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   passCount;
    exp_t sbQ[$];

    rv32_id_ex_stage_if #(.XLEN(32), .OPSEL_W(4), .STALL_CNT_W(16)) bus ();

    rv32_id_ex_stage #(.XLEN(32), .OPSEL_W(4), .STALL_CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    // Reference forwarding: the EX/MEM source wins over MEM/WB, register x0 is never forwarded.
    function automatic logic [31:0] modelFwd(input logic [4:0] addr, input logic [31:0] base);
        if (addr == 5'd0) return base;
        if (bus.mem_fwd_en && bus.mem_fwd_rd == addr) return bus.mem_fwd_data;
        if (bus.wb_fwd_en && bus.wb_fwd_rd == addr) return bus.wb_fwd_data;
        return base;
    endfunction

    task automatic setFwd(input logic mEn, input logic [4:0] mRd, input logic [31:0] mData,
                          input logic wEn, input logic [4:0] wRd, input logic [31:0] wData);
        bus.mem_fwd_en   = mEn;
        bus.mem_fwd_rd   = mRd;
        bus.mem_fwd_data = mData;
        bus.wb_fwd_en    = wEn;
        bus.wb_fwd_rd    = wRd;
        bus.wb_fwd_data  = wData;
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic [4:0] rs1a, input logic [31:0] rs1d,
                                 input logic [4:0] rs2a, input logic [31:0] rs2d, input logic [31:0] imm,
                                 input logic [4:0] rd, input logic [3:0] opsel, input logic useImm,
                                 input logic regWrite, input bit expectCapture);
        exp_t e;
        bus.id_valid     = 1'b1;
        bus.id_pc        = pc;
        bus.id_rs1_addr  = rs1a;
        bus.id_rs1_data  = rs1d;
        bus.id_rs2_addr  = rs2a;
        bus.id_rs2_data  = rs2d;
        bus.id_imm       = imm;
        bus.id_rd_addr   = rd;
        bus.id_alu_opsel = opsel;
        bus.id_use_imm   = useImm;
        bus.id_reg_write = regWrite;
        if (expectCapture) begin
            e.opA      = modelFwd(rs1a, rs1d);
            e.store    = modelFwd(rs2a, rs2d);
            e.opB      = useImm ? imm : e.store;
            e.opsel    = opsel;
            e.rd       = rd;
            e.regWrite = regWrite;
            e.pc       = pc;
            sbQ.push_back(e);
        end
    endtask

    task automatic popCheck(input string tag);
        exp_t e;
        checkOutput({tag, " valid"}, {31'd0, bus.ex_valid}, 32'd1);
        checkOutput({tag, " sbDepth"}, sbQ.size(), 32'd1);
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput({tag, " opA"},   bus.ex_opA, e.opA);
            checkOutput({tag, " opB"},   bus.ex_opB, e.opB);
            checkOutput({tag, " store"}, bus.ex_store_data, e.store);
            checkOutput({tag, " opsel"}, {28'd0, bus.ex_alu_opsel}, {28'd0, e.opsel});
            checkOutput({tag, " rd"},    {27'd0, bus.ex_rd_addr}, {27'd0, e.rd});
            checkOutput({tag, " regWr"}, {31'd0, bus.ex_reg_write}, {31'd0, e.regWrite});
            checkOutput({tag, " pc"},    bus.ex_pc, e.pc);
        end
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        rst_n      = 1'b0;
        bus.flush  = 1'b0;
        bus.ex_ready = 1'b1;
        setFwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        applyStimulus(32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        bus.id_valid = 1'b0;
        tick();
        tick();

        // Reset state
        checkOutput("rst ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        checkOutput("rst opB",      bus.ex_opB, 32'd0);
        checkOutput("rst stall",    {16'd0, bus.stall_cnt}, 32'd0);
        checkOutput("rst id_ready", {31'd0, bus.id_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // Basic capture, one-cycle latency
        applyStimulus(32'h100, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 5'd4, 4'd5, 1'b0, 1'b1, 1'b1);
        #1;
        checkOutput("t1 id_ready", {31'd0, bus.id_ready}, 32'd1);
        tick();
        popCheck("t1");

        // MEM forward beats WB forward
        setFwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
        applyStimulus(32'h104, 5'd3, 32'h11, 5'd2, 32'd7, 32'h0, 5'd5, 4'd2, 1'b0, 1'b1, 1'b1);
        tick();
        popCheck("t2mem");

        // WB-only forward
        setFwd(1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
        applyStimulus(32'h108, 5'd3, 32'h11, 5'd2, 32'd7, 32'h0, 5'd5, 4'd3, 1'b0, 1'b0, 1'b1);
        tick();
        popCheck("t2wb");

        // x0 is never forwarded
        setFwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
        applyStimulus(32'h10C, 5'd0, 32'h1234, 5'd0, 32'h4321, 32'h0, 5'd0, 4'd1, 1'b0, 1'b1, 1'b1);
        tick();
        popCheck("t2x0");
        checkOutput("t2x0 opA", bus.ex_opA, 32'h1234);

        // Immediate operand, store data still RS2
        setFwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        applyStimulus(32'h110, 5'd1, 32'd1, 5'd2, 32'd9, 32'hFFFF_FFF0, 5'd6, 4'd7, 1'b1, 1'b1, 1'b1);
        tick();
        popCheck("t3");
        checkOutput("t3 opB", bus.ex_opB, 32'hFFFF_FFF0);

        // Stall for 3 cycles, WB result for RS2 arrives in the second cycle
        applyStimulus(32'h114, 5'd1, 32'h31, 5'd6, 32'h66, 32'h0, 5'd7, 4'd4, 1'b0, 1'b1, 1'b1);
        tick();
        popCheck("t4cap");
        bus.ex_ready = 1'b0;
        applyStimulus(32'h200, 5'd9, 32'h99, 5'd10, 32'h98, 32'h0, 5'd11, 4'd9, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("t4 id_ready", {31'd0, bus.id_ready}, 32'd0);
        tick();
        setFwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h55);
        tick();
        setFwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        checkOutput("t4 stall",  {16'd0, bus.stall_cnt}, 32'd3);
        checkOutput("t4 store",  bus.ex_store_data, 32'h55);
        checkOutput("t4 opB",    bus.ex_opB, 32'h55);
        checkOutput("t4 opA",    bus.ex_opA, 32'h31);
        checkOutput("t4 pc",     bus.ex_pc, 32'h114);
        checkOutput("t4 rd",     {27'd0, bus.ex_rd_addr}, 32'd7);
        checkOutput("t4 valid",  {31'd0, bus.ex_valid}, 32'd1);

        // Flush dominates a simultaneous capture
        bus.ex_ready = 1'b1;
        bus.flush    = 1'b1;
        tick();
        bus.flush = 1'b0;
        checkOutput("t5 ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        checkOutput("t5 regWr",    {31'd0, bus.ex_reg_write}, 32'd0);
        checkOutput("t5 stall",    {16'd0, bus.stall_cnt}, 32'd3);

        // Drain: consumed without a new capture
        applyStimulus(32'h120, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd8, 4'd6, 1'b0, 1'b1, 1'b1);
        tick();
        popCheck("t5b");
        bus.id_valid = 1'b0;
        tick();
        checkOutput("t5b drain", {31'd0, bus.ex_valid}, 32'd0);

        // Async reset in the middle of a stall
        applyStimulus(32'h130, 5'd1, 32'h77, 5'd2, 32'h78, 32'h0, 5'd12, 4'd8, 1'b0, 1'b1, 1'b1);
        tick();
        popCheck("t6cap");
        bus.id_valid = 1'b0;
        bus.ex_ready = 1'b0;
        tick();
        tick();
        checkOutput("t6 stall pre", {16'd0, bus.stall_cnt}, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6 ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        checkOutput("t6 stall",    {16'd0, bus.stall_cnt}, 32'd0);
        checkOutput("t6 opA",      bus.ex_opA, 32'd0);
        checkOutput("t6 opB",      bus.ex_opB, 32'd0);
        checkOutput("t6 store",    bus.ex_store_data, 32'd0);
        checkOutput("t6 pc",       bus.ex_pc, 32'd0);
        checkOutput("t6 regWr",    {31'd0, bus.ex_reg_write}, 32'd0);
        checkOutput("t6 id_ready", {31'd0, bus.id_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        bus.ex_ready = 1'b1;

        // First capture after reset behaves as from idle
        applyStimulus(32'h140, 5'd4, 32'h44, 5'd5, 32'h45, 32'h0, 5'd13, 4'd10, 1'b0, 1'b1, 1'b1);
        tick();
        popCheck("t6post");
        checkOutput("t6post stall", {16'd0, bus.stall_cnt}, 32'd0);
        bus.id_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
